seq_accum16: RTL

Sequential accumulator stage built around the existing 16-bit ripple-carry adder (`ripple_carry_16_bit`). It accepts a stream of 16-bit operands over a valid/ready handshake and feeds each one, with the running total, through the adder. After N_OPS operands it presents the 16-bit total, a count of carry-outs and a sticky overflow flag on a valid/ready output. It sits directly in front of the adder as the operand source, and consumes the adder's sum/cout as the next accumulator value.

---
 rtl/accum_pkg.sv | 12 +
 rtl/ripple_carry_16_bit.sv | 24 ++
 rtl/seq_accum16.sv | 102 ++++++++++
 3 files changed

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared state encoding and datapath width for the sequential accumulator
package accum_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry_16_bit.sv
// rtl/ripple_carry_16_bit.sv - 16-bit combinational ripple-carry adder
module ripple_carry_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 16; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[16];

endmodule

// File: rtl/seq_accum16.sv
// rtl/seq_accum16.sv - sequential accumulator feeding one ripple-carry adder per cycle
// Collects N_OPS operands per job and reports the modular sum, carry count and overflow.
module seq_accum16
  import accum_pkg::*;
#(
  parameter int N_OPS   = 4,
  parameter int CNT_W   = 4,
  parameter int CARRY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sum,
  output logic [CARRY_W-1:0] out_carries,
  output logic               out_ovf,
  output logic               busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CARRY_W-1:0] carries_q, carries_d;
  logic               ovf_q, ovf_d;

  logic [DATA_W-1:0]  add_sum;
  logic               add_cout;

  ripple_carry_16_bit u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (in_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    carries_d = carries_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d     = '0;
          cnt_d     = '0;
          carries_d = '0;
          ovf_d     = 1'b0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (add_cout) begin
            // Saturate rather than wrap so the carry count never silently understates.
            if (&carries_q) ovf_d = 1'b1;
            else            carries_d = carries_q + CARRY_W'(1);
          end
          if (cnt_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      carries_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      carries_q <= carries_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_sum     = acc_q;
  assign out_carries = carries_q;
  assign out_ovf     = ovf_q;

endmodule
